// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Fetch is one word per cycle; redirects land one edge after ID presents them.
module if_stage #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] beq_a,
  input  logic [31:0] jump_a,
  input  logic [31:0] jr_a,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        pc_err,
  output logic [31:0] fetch_cnt
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  // 33-bit end bound so a window ending at 2^32 does not wrap to zero
  localparam logic [32:0] IMEM_END =
    {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) * 33'd4);

  logic [31:0] pc_q, pc_d;
  if_id_t      ifid_q, ifid_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] pc4;
  logic [31:0] npc;
  logic        pc_ok;
  logic        s_seq, s_beq, s_jmp, s_jr;

  assign pc4   = pc_q + 32'd4;
  assign pc_ok = (pc_q[1:0] == 2'b00)
               && (pc_q >= IMEM_BASE)
               && ({1'b0, pc_q} < IMEM_END);

  assign s_seq = (npc_sel == 2'b00);
  assign s_beq = (npc_sel == 2'b01);
  assign s_jmp = (npc_sel == 2'b10);
  assign s_jr  = (npc_sel == 2'b11);

  always_comb begin
    npc = pc4;
    unique case (1'b1)
      s_seq:   npc = pc4;
      s_beq:   npc = beq_a;
      s_jmp:   npc = jump_a;
      s_jr:    npc = jr_a;
      default: npc = pc4;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    // illegal PC is flagged even while the front end is frozen
    err_d  = err_q | ~pc_ok;
    if (!stall) begin
      pc_d       = npc;
      ifid_d.pc  = pc_q;
      ifid_d.pc4 = pc4;
      if (pc_ok) begin
        ifid_d.instr = imem_rdata;
        ifid_d.valid = 1'b1;
        cnt_d        = cnt_q + 32'd1;
      end else begin
        ifid_d.instr = 32'd0;
        ifid_d.valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= PC_RESET;
      ifid_q <= '0;
      cnt_q  <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = ifid_q.instr;
  assign if_id_pc    = ifid_q.pc;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_valid = ifid_q.valid;
  assign pc_err      = err_q;
  assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, redirects, stall,
// illegal PC, async reset and PC wrap on a second instance.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [31:0] beq_a, jump_a, jr_a;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
  logic        if_id_valid, pc_err;
  logic [31:0] fetch_cnt;
  logic        rd_mode;

  logic        w_reset;
  logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_cnt;
  logic        w_valid, w_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rd_mode ? {16'h2400, imem_addr[15:0]}
                              : 32'h2401_0001;

  if_stage u_dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel),
    .beq_a(beq_a), .jump_a(jump_a), .jr_a(jr_a),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .pc_err(pc_err), .fetch_cnt(fetch_cnt)
  );

  if_stage #(
    .PC_RESET(32'hFFFF_FFFC), .IMEM_BASE(32'hFFFF_F000)
  ) u_wrap (
    .clk(clk), .reset(w_reset), .stall(1'b0), .npc_sel(2'b00),
    .beq_a(32'd0), .jump_a(32'd0), .jr_a(32'd0),
    .imem_addr(w_addr), .imem_rdata(32'h1234_5678),
    .if_id_instr(w_instr), .if_id_pc(w_pc),
    .if_id_pc4(w_pc4), .if_id_valid(w_valid),
    .pc_err(w_err), .fetch_cnt(w_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; w_reset = 1'b1; stall = 1'b0; npc_sel = 2'b00;
    beq_a = '0; jump_a = '0; jr_a = '0; rd_mode = 1'b0;
    #3;
    check("rst_addr", imem_addr, 32'h3000);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc", if_id_pc, 32'h0);
    check("rst_pc4", if_id_pc4, 32'h0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_err", {31'd0, pc_err}, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("w_rst_addr", w_addr, 32'hFFFF_FFFC);
    reset = 1'b0; w_reset = 1'b0;

    // sequential fetch; wrap instance runs alongside
    tick();
    check("seq1_addr", imem_addr, 32'h3004);
    check("w_pc0", w_addr, 32'h0);
    check("w_ifpc", w_pc, 32'hFFFF_FFFC);
    check("w_pc4", w_pc4, 32'h0);
    check("w_err0", {31'd0, w_err}, 32'd0);
    check("w_valid0", {31'd0, w_valid}, 32'd1);
    tick();
    check("seq2_addr", imem_addr, 32'h3008);
    check("w_err1", {31'd0, w_err}, 32'd1);
    check("w_valid1", {31'd0, w_valid}, 32'd0);
    tick();
    check("seq3_addr", imem_addr, 32'h300C);
    check("seq3_pc", if_id_pc, 32'h3008);
    check("seq3_pc4", if_id_pc4, 32'h300C);
    check("seq3_cnt", fetch_cnt, 32'd3);
    check("seq3_valid", {31'd0, if_id_valid}, 32'd1);
    check("seq3_instr", if_id_instr, 32'h2401_0001);

    // redirects, delay slot kept
    do_reset();
    tick();
    check("br_pre", imem_addr, 32'h3004);
    npc_sel = 2'b01; beq_a = 32'h3020;
    tick();
    check("br_pc", imem_addr, 32'h3020);
    check("br_slot", if_id_pc, 32'h3004);
    check("br_valid", {31'd0, if_id_valid}, 32'd1);
    check("br_cnt", fetch_cnt, 32'd2);
    npc_sel = 2'b10; jump_a = 32'h3040;
    tick();
    check("j_pc", imem_addr, 32'h3040);
    check("j_slot", if_id_pc, 32'h3020);
    npc_sel = 2'b11; jr_a = 32'h3100;
    tick();
    check("jr_pc", imem_addr, 32'h3100);
    check("jr_cnt", fetch_cnt, 32'd4);

    // stall holds everything and ignores npc_sel
    rd_mode = 1'b1;
    jr_a = 32'h3010;
    tick();
    check("st_pre", imem_addr, 32'h3010);
    stall = 1'b1; npc_sel = 2'b10; jump_a = 32'h3080;
    tick();
    tick();
    check("st_pc", imem_addr, 32'h3010);
    check("st_ifpc", if_id_pc, 32'h3100);
    check("st_instr", if_id_instr, 32'h2400_3100);
    check("st_cnt", fetch_cnt, 32'd5);
    stall = 1'b0; npc_sel = 2'b00;
    tick();
    check("rel_pc", imem_addr, 32'h3014);
    check("rel_ifpc", if_id_pc, 32'h3010);
    check("rel_instr", if_id_instr, 32'h2400_3010);
    check("rel_cnt", fetch_cnt, 32'd6);

    // async reset between edges
    npc_sel = 2'b11; jr_a = 32'h3050;
    tick();
    check("ar_pre", imem_addr, 32'h3050);
    npc_sel = 2'b00;
    #2;
    reset = 1'b1;
    #1;
    check("ar_addr", imem_addr, 32'h3000);
    check("ar_cnt", fetch_cnt, 32'd0);
    check("ar_ifpc", if_id_pc, 32'h0);
    check("ar_instr", if_id_instr, 32'h0);
    check("ar_valid", {31'd0, if_id_valid}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    check("ar_first", if_id_pc, 32'h3000);
    check("ar_cnt1", fetch_cnt, 32'd1);

    // misaligned jr target
    npc_sel = 2'b11; jr_a = 32'h3002;
    tick();
    check("mis_pc", imem_addr, 32'h3002);
    check("mis_err0", {31'd0, pc_err}, 32'd0);
    npc_sel = 2'b00;
    tick();
    check("mis_valid", {31'd0, if_id_valid}, 32'd0);
    check("mis_instr", if_id_instr, 32'h0);
    check("mis_err", {31'd0, pc_err}, 32'd1);
    check("mis_cnt", fetch_cnt, 32'd2);
    check("mis_next", imem_addr, 32'h3006);
    npc_sel = 2'b11; jr_a = 32'h3000;
    tick();
    npc_sel = 2'b00;
    tick();
    check("stk_valid", {31'd0, if_id_valid}, 32'd1);
    check("stk_err", {31'd0, pc_err}, 32'd1);
    check("stk_cnt", fetch_cnt, 32'd3);

    // upper bound: 0x3FFC legal, 0x4000 illegal
    do_reset();
    npc_sel = 2'b11; jr_a = 32'h3FFC;
    tick();
    npc_sel = 2'b00;
    tick();
    check("hi_valid", {31'd0, if_id_valid}, 32'd1);
    check("hi_err0", {31'd0, pc_err}, 32'd0);
    check("hi_pc", imem_addr, 32'h4000);
    tick();
    check("hi_err", {31'd0, pc_err}, 32'd1);
    check("hi_inv", {31'd0, if_id_valid}, 32'd0);

    // lower bound while stalled
    do_reset();
    npc_sel = 2'b11; jr_a = 32'h2FFC;
    tick();
    check("lo_err0", {31'd0, pc_err}, 32'd0);
    stall = 1'b1;
    tick();
    check("lo_err", {31'd0, pc_err}, 32'd1);
    check("lo_cnt", fetch_cnt, 32'd1);
    check("lo_valid", {31'd0, if_id_valid}, 32'd1);
    check("lo_pc", imem_addr, 32'h2FFC);
    stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
